bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential shift-add-3 (double-dabble) converter. Turns an unsigned binary value into packed BCD digits. Sits directly upstream of the seven-segment display stage and drives its 16-bit num input, so values show in decimal instead of hex. A start/busy/done handshake lets the CPU-side logic request a conversion whenever the value to display changes.

Parameters:
IN_W, 16, width of binary input; also the number of shift cycles per conversion
BCD_DIGITS, 5, internal BCD digit count; must satisfy 10^BCD_DIGITS > 2^IN_W - 1
OUT_DIGITS, 4, digits presented on bcd_out; must be less than or equal to BCD_DIGITS

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  reset
start  in  1  conversion request; sampled only in IDLE
bin_in  in  IN_W  binary value; captured on the accepted start cycle
busy  out  1  high while a conversion is in progress (state != IDLE)
done  out  1  one-cycle pulse; bcd_out/ovf updated in the same cycle
bcd_out  out  4*OUT_DIGITS  packed BCD; digit 0 in [3:0]; held between conversions
ovf  out  1  value does not fit in OUT_DIGITS decimal digits; held with bcd_out

Behaviour:
- Reset: RST is synchronous, active-high. It forces state=IDLE, busy=0, done=0, bcd_out=0, ovf=0, and clears the scratch registers and counter.
- Reset mid-conversion aborts the conversion. No done pulse is produced and the previous bcd_out is lost (it reads 0).
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - On start=1: capture bin_in into the shift register, clear the BCD scratch (4*BCD_DIGITS bits), load counter=IN_W, go to SHIFT.
  - On start=0: stay in IDLE.
- SHIFT, each cycle:
  - Every scratch digit >= 5 gets +3 (4-bit add, no carry out of the digit).
  - Then {scratch, shiftreg} shifts left by 1.
  - Counter decrements.
  - When the counter reaches 1 during this cycle, the next state is FINISH. Exactly IN_W shift cycles occur.
- FINISH (one cycle):
  - bcd_out <= low OUT_DIGITS digits of scratch.
  - ovf <= OR of digits OUT_DIGITS..BCD_DIGITS-1.
  - done=1.
  - Next state is IDLE.
- Latency: start accepted at edge t gives done=1 and valid bcd_out in the cycle after edge t+IN_W+1 (17 cycles for IN_W=16). Throughput is one conversion per IN_W+2 cycles.
- start while busy (SHIFT or FINISH) is ignored and not queued. bin_in changes during a conversion have no effect.
- start held high continuously triggers back-to-back conversions, with one IDLE cycle between them.
- done is registered (Moore), never high for more than one cycle, and is 0 in IDLE.
- bin_in = 0 yields all-zero digits. bin_in = 2^IN_W-1 must not overflow the scratch; this is guaranteed by the BCD_DIGITS constraint.

Optional Feature:
Macro BCD_SATURATE_EN.
- Defined: when ovf is set in FINISH, bcd_out is forced to all-9 digits (16'h9999 for OUT_DIGITS=4). ovf behaves as before.
- Undefined: bcd_out is the low OUT_DIGITS digits, i.e. the value modulo 10^OUT_DIGITS. ovf is still reported.

Decomposition:
- Shared package bcd_pkg:
  - state typedef (IDLE/SHIFT/FINISH)
  - BCD_DIGIT_W=4
  - ADJ_THRESH=5 and ADJ_ADD=3
  - SAT_DIGIT=4'h9
- Sub-module bcd_digit_adj: combinational 4-bit "if >=5 add 3", instantiated BCD_DIGITS times in a generate loop.

Test Plan:
- Basic conversion: RST for 2 cycles, then start with bin_in=16'd1234 -> done exactly 17 cycles after the start edge, bcd_out=16'h1234, ovf=0, busy=1 for the 17 cycles in between.
- Boundaries: bin_in=0 -> bcd_out=16'h0000, ovf=0. bin_in=9999 -> bcd_out=16'h9999, ovf=0.
- Overflow: bin_in=10000 -> ovf=1, bcd_out=16'h0000 (16'h9999 with BCD_SATURATE_EN). bin_in=65535 -> ovf=1, bcd_out=16'h5535 (16'h9999 with BCD_SATURATE_EN).
- Start while busy: start with 42, pulse start with 777 at cycle 5 -> single done pulse, bcd_out=16'h0042; a new start accepted after done returns 16'h0777.
- Reset mid-conversion: start with 4321, assert RST at cycle 8 -> no done pulse, bcd_out=0, busy=0 on the next cycle; a fresh start then converts correctly.
- Continuous start held high with bin_in=1,2,3 -> three done pulses spaced 18 cycles apart, bcd_out=0001, 0002, 0003.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional feature macro used by the converter: BCD_SATURATE_EN.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;
    localparam logic [BCD_DIGIT_W-1:0] SAT_DIGIT  = 4'h9;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/response bundle between the CPU-side logic and the BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int IN_W       = 16,
    parameter int OUT_DIGITS = 4
);
    // Handshake: start is taken only while busy=0 and bin_in is captured on that
    // same edge; done pulses one cycle with bcd_out/ovf valid and held afterwards.
    logic                    start;
    logic [IN_W-1:0]         bin_in;
    logic                    busy;
    logic                    done;
    logic [4*OUT_DIGITS-1:0] bcd_out;
    logic                    ovf;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, ovf
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, ovf
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: a BCD digit of 5 or more gets 3 added.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake.
// Macro BCD_SATURATE_EN: on overflow, bcd_out is forced to all-9 digits.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W       = 16,
    parameter int BCD_DIGITS = 5,
    parameter int OUT_DIGITS = 4
) (
    input  logic              CLK,
    input  logic              RST,
    bin_to_bcd_seq_if.slave   bus,
    output state_t            dbg_state
);

    localparam int SCR_W = BCD_DIGIT_W * BCD_DIGITS;
    localparam int OUT_W = BCD_DIGIT_W * OUT_DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t            state;
    logic [IN_W-1:0]   shreg;
    logic [SCR_W-1:0]  scratch;
    logic [SCR_W-1:0]  scratch_adj;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_c;
    logic [OUT_W-1:0]  bcd_c;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Digits above the presented window must all be zero for the value to fit.
    always_comb begin
        ovf_c = 1'b0;
        for (int i = OUT_DIGITS; i < BCD_DIGITS; i++) begin
            ovf_c = ovf_c | (|scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
`ifdef BCD_SATURATE_EN
        bcd_c = ovf_c ? {OUT_DIGITS{SAT_DIGIT}} : scratch[OUT_W-1:0];
`else
        bcd_c = scratch[OUT_W-1:0];
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            shreg       <= '0;
            scratch     <= '0;
            cnt         <= '0;
            bus.done    <= 1'b0;
            bus.bcd_out <= '0;
            bus.ovf     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg   <= bus.bin_in;
                        scratch <= '0;
                        cnt     <= CNT_W'(IN_W);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, shreg} <= {scratch_adj, shreg} << 1;
                    cnt              <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bus.bcd_out <= bcd_c;
                    bus.ovf     <= ovf_c;
                    bus.done    <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: vector table plus handshake corner sequences.
module tb_bin_to_bcd_seq;
    import bcd_pkg::*;

    localparam int IN_W       = 16;
    localparam int BCD_DIGITS = 5;
    localparam int OUT_DIGITS = 4;
    localparam int LAT        = IN_W + 1;

    logic   CLK = 1'b0;
    logic   RST = 1'b1;
    state_t dbg_state;

    bin_to_bcd_seq_if #(.IN_W(IN_W), .OUT_DIGITS(OUT_DIGITS)) bus ();

    bin_to_bcd_seq #(
        .IN_W       (IN_W),
        .BCD_DIGITS (BCD_DIGITS),
        .OUT_DIGITS (OUT_DIGITS)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t        vecs [8];
    logic [16:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        prev_done = 1'b0;

    function automatic logic [16:0] expect_out(input logic [15:0] bcd, input logic o);
`ifdef BCD_SATURATE_EN
        if (o) bcd = 16'h9999;
`endif
        return {o, bcd};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_conv(input logic [15:0] v);
        @(negedge CLK);
        bus.start  = 1'b1;
        bus.bin_in = v;
        @(negedge CLK);
        bus.start  = 1'b0;
    endtask

    // Counts negedges until done; busy_ok drops if busy is wrong along the way.
    task automatic wait_done(input int maxc, output int cyc, output logic busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        while (cyc < maxc) begin
            @(negedge CLK);
            cyc++;
            if (bus.done) begin
                if (bus.busy) busy_ok = 1'b0;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (!RST && bus.done) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got ovf/bcd %0h, expected no done", {bus.ovf, bus.bcd_out});
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({bus.ovf, bus.bcd_out} !== e) begin
                    n_err++;
                    $display("FAIL result: got ovf/bcd %0h, expected %0h", {bus.ovf, bus.bcd_out}, e);
                end
            end
            if (prev_done) begin
                n_err++;
                $display("FAIL done_width: got done high 2 cycles, expected 1");
            end
        end
        prev_done <= bus.done;
    end

    initial begin
        int   cyc;
        logic bok;

        vecs[0] = '{16'd1234,  16'h1234, 1'b0};
        vecs[1] = '{16'd0,     16'h0000, 1'b0};
        vecs[2] = '{16'd9999,  16'h9999, 1'b0};
        vecs[3] = '{16'd10000, 16'h0000, 1'b1};
        vecs[4] = '{16'd65535, 16'h5535, 1'b1};
        vecs[5] = '{16'd100,   16'h0100, 1'b0};
        vecs[6] = '{16'd59999, 16'h9999, 1'b1};
        vecs[7] = '{16'd8,     16'h0008, 1'b0};

        bus.start  = 1'b0;
        bus.bin_in = '0;
        RST        = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("reset_busy",  {31'd0, bus.busy}, 32'd0);
        check("reset_done",  {31'd0, bus.done}, 32'd0);
        check("reset_bcd",   {16'd0, bus.bcd_out}, 32'd0);
        check("reset_ovf",   {31'd0, bus.ovf}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});

        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(expect_out(vecs[i].exp_bcd, vecs[i].exp_ovf));
            start_conv(vecs[i].bin);
            check("busy_after_start", {31'd0, bus.busy}, 32'd1);
            wait_done(40, cyc, bok);
            check("latency", cyc, LAT);
            check("busy_window", {31'd0, bok}, 32'd1);
            @(negedge CLK);
            check("done_low_after", {31'd0, bus.done}, 32'd0);
            check("bcd_held", {15'd0, bus.ovf, bus.bcd_out}, {15'd0, expect_out(vecs[i].exp_bcd, vecs[i].exp_ovf)});
        end

        // start while busy is ignored and not queued
        exp_q.push_back(expect_out(16'h0042, 1'b0));
        start_conv(16'd42);
        repeat (4) @(negedge CLK);
        bus.start  = 1'b1;
        bus.bin_in = 16'd777;
        @(negedge CLK);
        bus.start  = 1'b0;
        wait_done(40, cyc, bok);
        check("busy_start_latency", cyc, LAT - 5);
        repeat (25) @(negedge CLK);
        check("busy_start_idle", {31'd0, bus.busy}, 32'd0);
        exp_q.push_back(expect_out(16'h0777, 1'b0));
        start_conv(16'd777);
        wait_done(40, cyc, bok);
        check("after_busy_latency", cyc, LAT);

        // reset mid-conversion aborts without a done pulse
        start_conv(16'd4321);
        repeat (7) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy",  {31'd0, bus.busy}, 32'd0);
        check("abort_done",  {31'd0, bus.done}, 32'd0);
        check("abort_bcd",   {16'd0, bus.bcd_out}, 32'd0);
        check("abort_ovf",   {31'd0, bus.ovf}, 32'd0);
        check("abort_state", {30'd0, dbg_state}, {30'd0, IDLE});
        repeat (25) @(negedge CLK);
        check("abort_bcd_held", {16'd0, bus.bcd_out}, 32'd0);
        exp_q.push_back(expect_out(16'h4321, 1'b0));
        start_conv(16'd4321);
        wait_done(40, cyc, bok);
        check("post_abort_latency", cyc, LAT);

        // start held high: back-to-back conversions one IDLE cycle apart
        @(negedge CLK);
        for (int k = 0; k < 3; k++) exp_q.push_back(expect_out(16'(k + 1), 1'b0));
        bus.start  = 1'b1;
        bus.bin_in = 16'd1;
        for (int k = 0; k < 3; k++) begin
            wait_done(40, cyc, bok);
            check("b2b_spacing", cyc, LAT + 1);
            check("b2b_busy", {31'd0, bok}, 32'd1);
            bus.bin_in = 16'(k + 2);
        end
        bus.start = 1'b0;
        repeat (25) @(negedge CLK);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
